// File: rtl/fetch_arb.sv
// rtl/fetch_arb.sv - round-robin arbiter of cache fetch requests onto one fetch engine
//
// Several cache controllers share a single fetch engine. One fetch is in
// flight at a time; requesters are served round-robin starting after the
// last owner. The engine's accept (eng_gnt) and completion (eng_done) are
// steered back to the owning requester only. A watchdog raises a sticky
// flag when a granted fetch does not complete within done_timeout cycles.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_fetch_req       per-requester request, held until its grant
//   req_fetch_cmd       per-requester cmd, slice i = [2i+1:2i]
//   req_fetch_tag       per-requester line tag, slice i = [TW*i +: TW]
//   req_fetch_addr      per-requester line address
//   req_fetch_addr_pre  per-requester victim line address
//   req_fetch_gnt       one-hot grant pulse to the owner
//   req_fetch_done      one-hot completion pulse to the owner
//   eng_req             request to the fetch engine (ISSUE state)
//   eng_cmd/tag/addr/addr_pre  payload captured from the owner
//   eng_gnt, eng_done   engine accept and completion pulses
//   busy                a transaction is in ISSUE or WAIT_DONE
//   owner               index of the current owner
//   err_timeout         sticky watchdog flag
module fetch_arb #(
  parameter int addr_width   = 32,
  parameter int list_depth   = 4,
  parameter int num_req      = 2,
  parameter int done_timeout = 1024,
  localparam int TW = $clog2(list_depth),
  localparam int IW = $clog2(num_req)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [num_req-1:0]           req_fetch_req,
  input  logic [2*num_req-1:0]         req_fetch_cmd,
  input  logic [TW*num_req-1:0]        req_fetch_tag,
  input  logic [addr_width*num_req-1:0] req_fetch_addr,
  input  logic [addr_width*num_req-1:0] req_fetch_addr_pre,
  output logic [num_req-1:0]           req_fetch_gnt,
  output logic [num_req-1:0]           req_fetch_done,
  output logic                         eng_req,
  output logic [1:0]                   eng_cmd,
  output logic [TW-1:0]                eng_tag,
  output logic [addr_width-1:0]        eng_addr,
  output logic [addr_width-1:0]        eng_addr_pre,
  input  logic                         eng_gnt,
  input  logic                         eng_done,
  output logic                         busy,
  output logic [IW-1:0]                owner,
  output logic                         err_timeout
);

  localparam int WDW = $clog2(done_timeout);
  localparam logic [WDW-1:0] WD_LAST = WDW'(done_timeout - 1);
  localparam logic [IW-1:0]  LAST_REQ = IW'(num_req - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  owner_q;
  logic [WDW-1:0] wd_cnt;

  // arbitration result
  logic            hi_vld, lo_vld, pick_vld;
  logic [IW-1:0]   hi_pick, lo_pick, pick;
  logic [1:0]            pick_cmd;
  logic [TW-1:0]         pick_tag;
  logic [addr_width-1:0] pick_addr;
  logic [addr_width-1:0] pick_pre;

  logic [num_req-1:0] owner_oh;
  logic capture, grant;

  // Round-robin search split in two priority passes: the lowest requesting
  // index at or above rr_ptr wins; if none, the lowest requesting index
  // overall (the wrapped part of the search). Scanning downward makes the
  // last assignment the lowest index.
  always_comb begin
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    hi_pick = '0;
    lo_pick = '0;
    for (int i = num_req - 1; i >= 0; i--) begin
      if (req_fetch_req[i]) begin
        if (IW'(i) >= rr_ptr) begin
          hi_vld  = 1'b1;
          hi_pick = IW'(i);
        end
        lo_vld  = 1'b1;
        lo_pick = IW'(i);
      end
    end
    pick_vld = hi_vld | lo_vld;
    pick     = hi_vld ? hi_pick : lo_pick;
  end

  // Payload of the selected requester
  always_comb begin
    pick_cmd  = '0;
    pick_tag  = '0;
    pick_addr = '0;
    pick_pre  = '0;
    for (int i = 0; i < num_req; i++) begin
      if (pick == IW'(i)) begin
        pick_cmd  = req_fetch_cmd[2*i +: 2];
        pick_tag  = req_fetch_tag[TW*i +: TW];
        pick_addr = req_fetch_addr[addr_width*i +: addr_width];
        pick_pre  = req_fetch_addr_pre[addr_width*i +: addr_width];
      end
    end
  end

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < num_req; i++) begin
      owner_oh[i] = (owner_q == IW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs. eng_done outside WAIT_DONE and
  // eng_gnt outside ISSUE fall through to the defaults and are ignored.
  always_comb begin
    state_nxt      = state;
    capture        = 1'b0;
    grant          = 1'b0;
    eng_req        = 1'b0;
    req_fetch_gnt  = '0;
    req_fetch_done = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          capture   = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        eng_req = 1'b1;
        if (eng_gnt) begin
          grant         = 1'b1;
          req_fetch_gnt = owner_oh;
          state_nxt     = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (eng_done) begin
          req_fetch_done = owner_oh;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Owner, payload, round-robin pointer and watchdog
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= '0;
      rr_ptr       <= '0;
      eng_cmd      <= '0;
      eng_tag      <= '0;
      eng_addr     <= '0;
      eng_addr_pre <= '0;
      wd_cnt       <= '0;
      err_timeout  <= 1'b0;
    end else begin
      if (capture) begin
        owner_q      <= pick;
        eng_cmd      <= pick_cmd;
        eng_tag      <= pick_tag;
        eng_addr     <= pick_addr;
        eng_addr_pre <= pick_pre;
      end
      if (grant) begin
        rr_ptr <= (owner_q == LAST_REQ) ? '0 : owner_q + IW'(1);
        wd_cnt <= '0;
      end else if (state == WAIT_DONE && !eng_done) begin
        // counter parks at its last value; the flag stays set until reset
        if (wd_cnt == WD_LAST) begin
          err_timeout <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + WDW'(1);
        end
      end
    end
  end

  assign busy  = (state != IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_fetch_arb.sv
// tb/tb_fetch_arb.sv - scoreboard testbench for fetch_arb
module tb_fetch_arb;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int LD = 4;
  localparam int TW = 2;
  localparam int IW = 2;
  localparam int DT = 8;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_bits;
  logic [2*N-1:0]    req_cmd;
  logic [TW*N-1:0]   req_tag;
  logic [AW*N-1:0]   req_addr;
  logic [AW*N-1:0]   req_pre;
  logic [N-1:0]      req_fetch_gnt;
  logic [N-1:0]      req_fetch_done;
  logic              eng_req;
  logic [1:0]        eng_cmd;
  logic [TW-1:0]     eng_tag;
  logic [AW-1:0]     eng_addr;
  logic [AW-1:0]     eng_addr_pre;
  logic              eng_gnt;
  logic              eng_done;
  logic              busy;
  logic [IW-1:0]     owner;
  logic              err_timeout;

  fetch_arb #(
    .addr_width  (AW),
    .list_depth  (LD),
    .num_req     (N),
    .done_timeout(DT)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_fetch_req     (req_bits),
    .req_fetch_cmd     (req_cmd),
    .req_fetch_tag     (req_tag),
    .req_fetch_addr    (req_addr),
    .req_fetch_addr_pre(req_pre),
    .req_fetch_gnt     (req_fetch_gnt),
    .req_fetch_done    (req_fetch_done),
    .eng_req           (eng_req),
    .eng_cmd           (eng_cmd),
    .eng_tag           (eng_tag),
    .eng_addr          (eng_addr),
    .eng_addr_pre      (eng_addr_pre),
    .eng_gnt           (eng_gnt),
    .eng_done          (eng_done),
    .busy              (busy),
    .owner             (owner),
    .err_timeout       (err_timeout)
  );

  typedef struct {
    int            owner;
    logic [1:0]    cmd;
    logic [TW-1:0] tag;
    logic [AW-1:0] addr;
    logic [AW-1:0] pre;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  int   checks = 0;
  int   errors = 0;
  bit   issue_seen = 0;
  bit   waiting = 0;
  logic [N-1:0] exp_gnt;
  logic [N-1:0] exp_done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_busy"}, busy, 0);
    check({pfx, "_eng_req"}, eng_req, 0);
    check({pfx, "_eng_cmd"}, eng_cmd, 0);
    check({pfx, "_eng_tag"}, eng_tag, 0);
    check({pfx, "_eng_addr"}, eng_addr, 0);
    check({pfx, "_eng_pre"}, eng_addr_pre, 0);
    check({pfx, "_owner"}, owner, 0);
    check({pfx, "_err"}, err_timeout, 0);
    check({pfx, "_gnt"}, req_fetch_gnt, 0);
    check({pfx, "_done"}, req_fetch_done, 0);
  endtask

  task automatic set_req(input int i, input logic [1:0] c, input logic [TW-1:0] t,
                         input logic [AW-1:0] a, input logic [AW-1:0] p);
    req_cmd[2*i +: 2]   = c;
    req_tag[TW*i +: TW] = t;
    req_addr[AW*i +: AW] = a;
    req_pre[AW*i +: AW]  = p;
  endtask

  task automatic expect_txn(input int o);
    txn_t t;
    t.owner = o;
    t.cmd   = req_cmd[2*o +: 2];
    t.tag   = req_tag[TW*o +: TW];
    t.addr  = req_addr[AW*o +: AW];
    t.pre   = req_pre[AW*o +: AW];
    exp_q.push_back(t);
  endtask

  // Expects requester o to win, waits for eng_req, stalls gnt_wait cycles
  // (optionally scrambling o's inputs), pulses eng_gnt, then drops `drop`.
  task automatic issue_and_grant(input int o, input int gnt_wait,
                                 input logic [N-1:0] drop, input bit scramble);
    int t;
    t = 0;
    expect_txn(o);
    while (!eng_req && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("issue_seen", eng_req, 1);
    for (int k = 0; k < gnt_wait; k++) begin
      if (scramble) begin
        req_addr[AW*o +: AW] = $urandom;
        req_pre[AW*o +: AW]  = $urandom;
        req_tag[TW*o +: TW]  = ~req_tag[TW*o +: TW];
        req_cmd[2*o +: 2]    = ~req_cmd[2*o +: 2];
      end
      @(posedge clk); #1;
    end
    eng_gnt = 1'b1;
    @(posedge clk); #1;
    eng_gnt  = 1'b0;
    req_bits = req_bits & ~drop;
  endtask

  // Waits done_wait cycles in WAIT_DONE, pulses eng_done (raising `raise`
  // in the same cycle) and checks the one-cycle IDLE bubble afterwards.
  task automatic finish(input int done_wait, input logic [N-1:0] raise);
    for (int k = 0; k < done_wait; k++) begin
      @(posedge clk); #1;
    end
    eng_done = 1'b1;
    req_bits = req_bits | raise;
    @(posedge clk); #1;
    eng_done = 1'b0;
    check("idle_after_done", {busy, eng_req}, 0);
  endtask

  // Scoreboard monitor: pops an expected transaction at the first ISSUE
  // cycle, checks payload throughout ISSUE and the routed gnt/done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        issue_seen = 0;
        waiting    = 0;
      end else begin
        if (eng_req && !issue_seen) begin
          issue_seen = 1;
          check("queue_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) cur = exp_q.pop_front();
        end
        if (eng_req) begin
          check("owner", owner, cur.owner);
          check("eng_cmd", eng_cmd, cur.cmd);
          check("eng_tag", eng_tag, cur.tag);
          check("eng_addr", eng_addr, cur.addr);
          check("eng_pre", eng_addr_pre, cur.pre);
        end
        exp_gnt = '0;
        if (eng_req && eng_gnt) exp_gnt[cur.owner] = 1'b1;
        check("gnt_route", req_fetch_gnt, exp_gnt);
        exp_done = '0;
        if (waiting && eng_done) exp_done[cur.owner] = 1'b1;
        check("done_route", req_fetch_done, exp_done);
        if (waiting && eng_done) waiting = 0;
        if (eng_req && eng_gnt) begin
          waiting    = 1;
          issue_seen = 0;
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    req_bits = '0;
    req_cmd  = '0;
    req_tag  = '0;
    req_addr = '0;
    req_pre  = '0;
    eng_gnt  = 1'b0;
    eng_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("post_rst");

    // 1: single request with exact cycle timing
    set_req(0, 2'b01, 2'd2, 32'h1000, 32'h2000);
    req_bits[0] = 1'b1;
    expect_txn(0);
    @(negedge clk);
    check("t1_no_bypass", eng_req, 0);
    @(posedge clk); #1;
    check("t1_eng_req", eng_req, 1);
    check("t1_busy", busy, 1);
    @(posedge clk); #1;
    eng_gnt = 1'b1;
    @(negedge clk);
    check("t1_gnt", req_fetch_gnt, 3'b001);
    @(posedge clk); #1;
    eng_gnt     = 1'b0;
    req_bits[0] = 1'b0;
    check("t1_wait_no_req", eng_req, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    eng_done = 1'b1;
    @(negedge clk);
    check("t1_done", req_fetch_done, 3'b001);
    @(posedge clk); #1;
    eng_done = 1'b0;
    check("t1_idle", busy, 0);

    // 2: two requesters held continuously alternate (pointer now at 1)
    set_req(0, 2'b01, 2'd1, 32'h0000_A000, 32'h0000_B000);
    set_req(1, 2'b10, 2'd3, 32'h0001_C000, 32'h0001_D000);
    req_bits = 3'b011;
    issue_and_grant(1, 0, 3'b000, 0);
    finish(0, 3'b000);
    issue_and_grant(0, 0, 3'b000, 0);
    finish(0, 3'b000);
    issue_and_grant(1, 0, 3'b000, 0);
    finish(0, 3'b000);
    issue_and_grant(0, 0, 3'b011, 0);
    finish(0, 3'b000);

    // 3: req1 appears in the cycle owner 0 completes
    set_req(0, 2'b10, 2'd0, 32'h0002_0000, 32'h0003_0000);
    req_bits[0] = 1'b1;
    issue_and_grant(0, 0, 3'b001, 0);
    set_req(1, 2'b01, 2'd2, 32'h0004_0040, 32'h0005_0040);
    finish(2, 3'b010);
    issue_and_grant(1, 1, 3'b010, 0);
    finish(0, 3'b000);

    // 4: 50-cycle engine stall with changing requester inputs
    set_req(2, 2'b01, 2'd3, 32'hDEAD_0000, 32'hBEEF_0000);
    req_bits[2] = 1'b1;
    issue_and_grant(2, 50, 3'b100, 1);
    finish(1, 3'b000);
    check("t4_err", err_timeout, 0);

    // 5: watchdog
    set_req(0, 2'b01, 2'd1, 32'h0000_0100, 32'h0000_0200);
    req_bits[0] = 1'b1;
    issue_and_grant(0, 0, 3'b001, 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("t5_err_early", err_timeout, 0);
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("t5_err_set", err_timeout, 1);
    check("t5_still_busy", busy, 1);
    finish(0, 3'b000);
    check("t5_err_sticky", err_timeout, 1);

    // 6: reset in WAIT_DONE, stale done, pointer back to 0
    set_req(1, 2'b10, 2'd2, 32'h0000_7700, 32'h0000_8800);
    req_bits[1] = 1'b1;
    issue_and_grant(1, 0, 3'b010, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    @(posedge clk); #1;
    eng_done = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_stale_done", req_fetch_done, 0);
    check("t6_stale_busy", busy, 0);
    @(posedge clk); #1;
    eng_done = 1'b0;
    set_req(0, 2'b01, 2'd3, 32'h0009_0000, 32'h000A_0000);
    set_req(2, 2'b10, 2'd0, 32'h000B_0000, 32'h000C_0000);
    req_bits = 3'b101;
    issue_and_grant(0, 0, 3'b101, 0);
    finish(0, 3'b000);

    @(posedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_arb.md
Name: fetch_arb

Overview:
Arbitrates line-fill/write-back fetch requests from several cache controllers (read controller, write controller, ...) onto the single fetch engine port.
- Only one fetch transaction is outstanding at a time.
- Grants are round-robin.
- The engine handshake (gnt) and completion (done) are routed back to the owning requester only.
- A watchdog flags fetches that never complete.

Parameters:
addr_width, 32, byte address width of fetch_addr / fetch_addr_pre
list_depth, 4, cache lines; tag width TW = $clog2(list_depth)
num_req, 2, number of requesters (>=2); index width IW = $clog2(num_req)
done_timeout, 1024, cycles in WAIT_DONE before err_timeout sets (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_fetch_req  in  num_req  per-requester fetch request; held until its gnt
req_fetch_cmd  in  2*num_req  per-requester cmd (2'b01 fetch, 2'b10 write-back+fetch), slice i = [2i+1:2i]
req_fetch_tag  in  TW*num_req  per-requester line tag
req_fetch_addr  in  addr_width*num_req  per-requester line address to fetch
req_fetch_addr_pre  in  addr_width*num_req  per-requester victim line address
req_fetch_gnt  out  num_req  one-hot grant pulse to owner
req_fetch_done  out  num_req  one-hot completion pulse to owner
eng_req  out  1  request to fetch engine
eng_cmd  out  2  registered cmd of owner
eng_tag  out  TW  registered tag
eng_addr  out  addr_width  registered address
eng_addr_pre  out  addr_width  registered victim address
eng_gnt  in  1  engine accepts eng_req
eng_done  in  1  engine completion pulse
busy  out  1  state != IDLE
owner  out  IW  index of current owner (valid when busy)
err_timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, rr_ptr=0, owner=0.
  - eng_cmd/eng_tag/eng_addr/eng_addr_pre=0.
  - err_timeout=0, wd counter=0.
  - All outputs 0.
  - Reset mid-transaction drops the transaction; no done is delivered.
- States: IDLE, ISSUE, WAIT_DONE.
- IDLE:
  - If any req_fetch_req bit is set, select the first set bit searching from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., num_req-1, 0, ...).
  - Register owner and that requester's cmd/tag/addr/addr_pre.
  - Next state ISSUE.
  - Latency: req high at cycle t -> eng_req high at t+1.
- ISSUE:
  - eng_req=1; payload held stable.
  - On eng_gnt: req_fetch_gnt[owner]=1 in the same cycle (combinational); rr_ptr <= (owner+1) mod num_req; wd counter cleared; next state WAIT_DONE.
  - Without eng_gnt: stay in ISSUE indefinitely, no timeout.
- WAIT_DONE:
  - eng_req=0.
  - On eng_done: req_fetch_done[owner]=1 in the same cycle; next state IDLE.
  - Otherwise the wd counter increments, saturating. When it reaches done_timeout-1, err_timeout <= 1 (sticky until reset). The FSM keeps waiting.
- Simultaneous events:
  - eng_done and new requests in the same cycle: finish first; arbitration happens in the following IDLE cycle (one bubble, no bypass).
  - eng_done in IDLE or ISSUE: ignored, no done pulse.
  - eng_gnt outside ISSUE: ignored.
- Fairness: a continuously requesting requester waits at most num_req-1 transactions.
- Protocol:
  - A requester deasserting fetch_req before its gnt is a violation. The arbiter still completes the captured transaction and routes gnt/done to that owner.
  - Payload sampled only at IDLE->ISSUE; later changes on req_* are ignored.
- Output constraints: req_fetch_gnt and req_fetch_done are never both nonzero in the same cycle, and each is at most one-hot.
- busy=1 in ISSUE and WAIT_DONE.

Test Plan:
1. Single request: req0 fetch (cmd=01, tag=2, addr=0x1000, pre=0x2000) at cycle 1 -> eng_req at cycle 2 with those values; eng_gnt at cycle 3 -> gnt[0] at cycle 3; eng_done at cycle 6 -> done[0] at cycle 6; busy low at cycle 7.
2. Round-robin: req0 and req1 held continuously, engine grants/dones immediately -> owners alternate 0,1,0,1; never two grants in a row to one requester while the other waits.
3. Done/request overlap: req1 asserted during the cycle eng_done completes owner 0 -> IDLE for one cycle, then ISSUE with owner=1; done[1] never pulses for owner 0's completion.
4. Stall: eng_gnt held low 50 cycles -> eng_req and payload stable, no gnt pulse, err_timeout stays 0.
5. Watchdog: with done_timeout=8, no eng_done for 8 cycles after grant -> err_timeout=1 and stays 1; a later eng_done still gives done[owner] and returns to IDLE.
6. Reset mid-op: assert rst_n low in WAIT_DONE -> all outputs 0 immediately; after release, a stale eng_done produces no done pulse and rr_ptr=0 (req0 wins a tie).
